// File: rtl/jtgng_sdram_rd.sv
// SDRAM command sequencer: power-up init, toggle-triggered single-word reads,
// download writes and auto-refresh on a single-bank SDR SDRAM.
module jtgng_sdram_rd #(
    parameter int CAS_LAT   = 2,
    parameter int INIT_WAIT = 9600
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sdram_re,
    input  logic [21:0] sdram_addr,
    input  logic        autorefresh,
    input  logic        prog_we,
    input  logic [21:0] prog_addr,
    input  logic [15:0] prog_data,
    input  logic [1:0]  prog_mask,
    output logic        prog_ack,
    output logic [15:0] data_read,
    output logic        init_done,
    output logic [12:0] SDRAM_A,
    output logic [1:0]  SDRAM_BA,
    output logic        SDRAM_nCS,
    output logic        SDRAM_nRAS,
    output logic        SDRAM_nCAS,
    output logic        SDRAM_nWE,
    output logic        SDRAM_DQML,
    output logic        SDRAM_DQMH,
    input  logic [15:0] dq_in,
    output logic [15:0] dq_out,
    output logic        dq_oe
);

    localparam int CW = 16;

    localparam logic [3:0] CMD_INHIBIT = 4'b1111;
    localparam logic [3:0] CMD_NOP     = 4'b0111;
    localparam logic [3:0] CMD_ACT     = 4'b0011;
    localparam logic [3:0] CMD_READ    = 4'b0101;
    localparam logic [3:0] CMD_WRITE   = 4'b0100;
    localparam logic [3:0] CMD_PRE     = 4'b0010;
    localparam logic [3:0] CMD_REF     = 4'b0001;
    localparam logic [3:0] CMD_MRS     = 4'b0000;

    localparam logic [3:0] ST_WAIT   = 4'd0;
    localparam logic [3:0] ST_PREALL = 4'd1;
    localparam logic [3:0] ST_REF1   = 4'd2;
    localparam logic [3:0] ST_REF2   = 4'd3;
    localparam logic [3:0] ST_MRS    = 4'd4;
    localparam logic [3:0] ST_IDLE   = 4'd5;
    localparam logic [3:0] ST_ACT_RD = 4'd6;
    localparam logic [3:0] ST_ACT_WR = 4'd7;
    localparam logic [3:0] ST_REF    = 4'd8;

    // single-location writes, sequential burst of 1
    localparam logic [12:0] MODE_WORD = {3'b000, 1'b1, 2'b00, 3'(CAS_LAT), 1'b0, 3'b000};

    logic [3:0]    cmd;
    logic [1:0]    dqm;
    logic [3:0]    state;
    logic [CW-1:0] cnt;
    logic          re_last;
    logic [8:0]    col;

    assign {SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE} = cmd;
    assign SDRAM_DQMH = dqm[1];
    assign SDRAM_DQML = dqm[0];
    assign SDRAM_BA   = '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_WAIT;
            cnt       <= '0;
            cmd       <= CMD_INHIBIT;
            SDRAM_A   <= '0;
            dqm       <= '1;
            dq_oe     <= 1'b0;
            dq_out    <= '0;
            data_read <= '0;
            init_done <= 1'b0;
            prog_ack  <= 1'b0;
            re_last   <= 1'b0;
            col       <= '0;
        end else begin
            cmd      <= CMD_NOP;
            dq_oe    <= 1'b0;
            prog_ack <= 1'b0;
            case (state)
                ST_WAIT: begin
                    if (cnt == CW'(INIT_WAIT - 1)) begin
                        state <= ST_PREALL;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_PREALL: begin
                    if (cnt == '0) begin
                        cmd     <= CMD_PRE;
                        SDRAM_A <= 13'h0400;
                    end
                    if (cnt == CW'(2)) begin
                        state <= ST_REF1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_REF1, ST_REF2: begin
                    if (cnt == '0) cmd <= CMD_REF;
                    if (cnt == CW'(7)) begin
                        state <= (state == ST_REF1) ? ST_REF2 : ST_MRS;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_MRS: begin
                    if (cnt == '0) begin
                        cmd     <= CMD_MRS;
                        SDRAM_A <= MODE_WORD;
                    end
                    if (cnt == CW'(2)) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_IDLE: begin
                    init_done <= 1'b1;
                    dqm       <= '1;
                    cnt       <= '0;
                    // a pending edge is consumed only here, so none is lost while busy
                    if (sdram_re != re_last) begin
                        re_last <= sdram_re;
                        cmd     <= CMD_ACT;
                        SDRAM_A <= sdram_addr[21:9];
                        col     <= sdram_addr[8:0];
                        state   <= ST_ACT_RD;
                    end else if (autorefresh) begin
                        cmd   <= CMD_REF;
                        state <= ST_REF;
                    end else if (prog_we) begin
                        cmd     <= CMD_ACT;
                        SDRAM_A <= prog_addr[21:9];
                        col     <= prog_addr[8:0];
                        state   <= ST_ACT_WR;
                    end
                end
                ST_ACT_RD: begin
                    if (cnt == CW'(1)) begin
                        cmd     <= CMD_READ;
                        SDRAM_A <= {2'b00, 1'b1, 1'b0, col};
                        dqm     <= 2'b00;
                    end
                    if (cnt == CW'(CAS_LAT + 2)) begin
                        data_read <= dq_in;
                        state     <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_ACT_WR: begin
                    if (cnt == CW'(1)) begin
                        cmd      <= CMD_WRITE;
                        SDRAM_A  <= {2'b00, 1'b1, 1'b0, col};
                        dq_out   <= prog_data;
                        dq_oe    <= 1'b1;
                        dqm      <= prog_mask;
                        prog_ack <= 1'b1;
                    end
                    if (cnt == CW'(2)) dqm <= '1;
                    if (cnt == CW'(4)) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                ST_REF: begin
                    if (cnt == CW'(6)) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= ST_WAIT;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtgng_sdram_rd.sv
// Directed bench for jtgng_sdram_rd with a behavioural SDRAM model and a
// queue of expected read words.
module tb_jtgng_sdram_rd;

    localparam int CL = 2;
    localparam int IW = 16;

    localparam logic [3:0] C_INH   = 4'b1111;
    localparam logic [3:0] C_NOP   = 4'b0111;
    localparam logic [3:0] C_ACT   = 4'b0011;
    localparam logic [3:0] C_READ  = 4'b0101;
    localparam logic [3:0] C_WRITE = 4'b0100;
    localparam logic [3:0] C_PRE   = 4'b0010;
    localparam logic [3:0] C_REF   = 4'b0001;
    localparam logic [3:0] C_MRS   = 4'b0000;

    logic        clk;
    logic        rst_n;
    logic        sdram_re;
    logic [21:0] sdram_addr;
    logic        autorefresh;
    logic        prog_we;
    logic [21:0] prog_addr;
    logic [15:0] prog_data;
    logic [1:0]  prog_mask;
    logic        prog_ack;
    logic [15:0] data_read;
    logic        init_done;
    logic [12:0] SDRAM_A;
    logic [1:0]  SDRAM_BA;
    logic        SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE;
    logic        SDRAM_DQML, SDRAM_DQMH;
    logic [15:0] dq_in;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic [3:0]  pins;

    assign pins = {SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE};

    jtgng_sdram_rd #(.CAS_LAT(CL), .INIT_WAIT(IW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sdram_re   (sdram_re),
        .sdram_addr (sdram_addr),
        .autorefresh(autorefresh),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .prog_mask  (prog_mask),
        .prog_ack   (prog_ack),
        .data_read  (data_read),
        .init_done  (init_done),
        .SDRAM_A    (SDRAM_A),
        .SDRAM_BA   (SDRAM_BA),
        .SDRAM_nCS  (SDRAM_nCS),
        .SDRAM_nRAS (SDRAM_nRAS),
        .SDRAM_nCAS (SDRAM_nCAS),
        .SDRAM_nWE  (SDRAM_nWE),
        .SDRAM_DQML (SDRAM_DQML),
        .SDRAM_DQMH (SDRAM_DQMH),
        .dq_in      (dq_in),
        .dq_out     (dq_out),
        .dq_oe      (dq_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          ncmp = 0;
    int          nfail = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mem[logic [21:0]];

    function automatic logic [15:0] mword(input logic [21:0] a);
        if (mem.exists(a)) return mem[a];
        return a[15:0] ^ 16'h5A3C;
    endfunction

    // SDRAM model: data is presented only in the single cycle the controller should capture it
    logic [12:0] open_row = '0;
    logic [21:0] rd_addr = '0;
    int          rd_cnt = -1;
    always @(negedge clk) begin
        logic [15:0] w;
        logic [21:0] wa;
        if (rd_cnt >= 0) rd_cnt = rd_cnt + 1;
        if (pins == C_ACT) open_row = SDRAM_A;
        if (pins == C_READ) begin
            rd_addr = {open_row[12:0], SDRAM_A[8:0]};
            rd_cnt  = 0;
        end
        if (pins == C_WRITE && dq_oe) begin
            wa = {open_row[12:0], SDRAM_A[8:0]};
            w  = mword(wa);
            if (!SDRAM_DQML) w[7:0] = dq_out[7:0];
            if (!SDRAM_DQMH) w[15:8] = dq_out[15:8];
            mem[wa] = w;
        end
        if (rd_cnt == CL) begin
            dq_in = mword(rd_addr);
        end else begin
            dq_in = 16'hDEAD;
            if (rd_cnt > CL) rd_cnt = -1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cmd(input logic [3:0] c, output int n);
        n = 0;
        while (pins != c && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic do_read(input logic [21:0] addr, input int exp_lat);
        int          n;
        logic [15:0] old;
        logic [15:0] e;
        logic [12:0] ea;
        old        = data_read;
        sdram_addr = addr;
        sdram_re   = ~sdram_re;
        exp_q.push_back(mword(addr));
        wait_cmd(C_ACT, n);
        chk("rd_latency", 32'(n), 32'(exp_lat));
        chk("act_row", 32'(SDRAM_A), 32'(addr[21:9]));
        step();
        step();
        ea = {2'b00, 1'b1, 1'b0, addr[8:0]};
        chk("read_cmd", 32'(pins), 32'(C_READ));
        chk("read_addr", 32'(SDRAM_A), 32'(ea));
        chk("read_dqm", 32'({SDRAM_DQMH, SDRAM_DQML}), 32'(0));
        step();
        step();
        chk("data_hold", 32'(data_read), 32'(old));
        step();
        e = exp_q.pop_front();
        chk("read_data", 32'(data_read), 32'(e));
    endtask

    // expects rst_n just released after an edge; the next edge is cycle 0
    task automatic init_seq();
        logic [3:0] e;
        for (int n = 0; n <= 38; n++) begin
            step();
            case (n)
                16:      e = C_PRE;
                19, 27:  e = C_REF;
                35:      e = C_MRS;
                default: e = C_NOP;
            endcase
            chk("init_cmd", 32'(pins), 32'(e));
            chk("init_done", 32'(init_done), 32'(n >= 38));
            if (n == 16) chk("pre_a10", 32'(SDRAM_A), 32'(13'h0400));
            if (n == 35) chk("mrs_word", 32'(SDRAM_A), 32'(13'h0220));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n;
        rst_n       = 1'b0;
        sdram_re    = 1'b0;
        sdram_addr  = '0;
        autorefresh = 1'b0;
        prog_we     = 1'b0;
        prog_addr   = '0;
        prog_data   = '0;
        prog_mask   = 2'b00;
        mem[22'h24123] = 16'hBEEF;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd", 32'(pins), 32'(C_INH));
        chk("rst_a", 32'(SDRAM_A), 32'(0));
        chk("rst_ba", 32'(SDRAM_BA), 32'(0));
        chk("rst_dqm", 32'({SDRAM_DQMH, SDRAM_DQML}), 32'(2'b11));
        chk("rst_oe", 32'(dq_oe), 32'(0));
        chk("rst_dqout", 32'(dq_out), 32'(0));
        chk("rst_data", 32'(data_read), 32'(0));
        chk("rst_init", 32'(init_done), 32'(0));
        chk("rst_ack", 32'(prog_ack), 32'(0));

        rst_n = 1'b1;
        init_seq();

        do_read(22'h24123, 1);
        chk("beef", 32'(data_read), 32'(16'hBEEF));
        step();
        step();

        for (int i = 0; i < 64; i++) begin
            do_read(22'h10000 + 22'(i * 583), 1);
            step();
            step();
        end

        repeat (3) step();
        prog_addr = 22'h4C000;
        prog_data = 16'h1234;
        prog_mask = 2'b01;
        prog_we   = 1'b1;
        wait_cmd(C_ACT, n);
        chk("wr_latency", 32'(n), 32'(1));
        chk("wr_row", 32'(SDRAM_A), 32'(13'h0260));
        step();
        chk("ack_early", 32'(prog_ack), 32'(0));
        step();
        chk("write_cmd", 32'(pins), 32'(C_WRITE));
        chk("write_addr", 32'(SDRAM_A), 32'(13'h0400));
        chk("write_dqml", 32'(SDRAM_DQML), 32'(1));
        chk("write_dqmh", 32'(SDRAM_DQMH), 32'(0));
        chk("write_oe", 32'(dq_oe), 32'(1));
        chk("write_dq", 32'(dq_out), 32'(16'h1234));
        chk("write_ack", 32'(prog_ack), 32'(1));
        prog_we = 1'b0;
        step();
        chk("oe_drop", 32'(dq_oe), 32'(0));
        chk("ack_drop", 32'(prog_ack), 32'(0));
        chk("wr_nop", 32'(pins), 32'(C_NOP));
        repeat (3) step();
        do_read(22'h4C000, 1);
        chk("wr_msb", 32'(data_read[15:8]), 32'(8'h12));

        repeat (4) step();
        autorefresh = 1'b1;
        wait_cmd(C_REF, n);
        chk("ref_latency", 32'(n), 32'(1));
        autorefresh = 1'b0;
        step();
        do_read(22'h0A5A5, 7);

        repeat (4) step();
        if (sdram_re == 1'b0) begin
            do_read(22'h00777, 1);
            repeat (4) step();
        end
        sdram_addr = 22'h3FF1FF;
        sdram_re   = ~sdram_re;
        exp_q.push_back(mword(22'h3FF1FF));
        wait_cmd(C_ACT, n);
        chk("rr_latency", 32'(n), 32'(1));
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_inh", 32'(pins), 32'(C_INH));
        chk("async_data", 32'(data_read), 32'(0));
        chk("async_init", 32'(init_done), 32'(0));
        chk("async_a", 32'(SDRAM_A), 32'(0));
        void'(exp_q.pop_front());
        step();
        step();
        chk("rst_hold", 32'(pins), 32'(C_INH));
        rst_n = 1'b1;
        init_seq();
        do_read(22'h120ABC, 1);
        chk("sb_empty", 32'(exp_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
